cv32e40x_rvfi_memop_collector: RTL and testbench
================================================

CV32E40X_RVFI_MEMOP_COLLECTOR -- requirements
Module: cv32e40x_rvfi_memop_collector

Interface
REQ-001 Parameter: NMEM, default 4, number of memory-transfer slots per retired instruction (range 1..8).
REQ-002 clk  input  1  core clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous and active-low.
REQ-004 lsu_valid_i  input  1  one completed LSU transfer this cycle.
REQ-005 lsu_we_i  input  1  transfer is a store (1) or a load (0).
REQ-006 lsu_be_i  input  4  byte enables of the transfer.
REQ-007 lsu_addr_i  input  32  transfer address.
REQ-008 lsu_wdata_i  input  32  store data.
REQ-009 lsu_rdata_i  input  32  load response data.
REQ-010 wb_valid_i  input  1  instruction retires this cycle.
REQ-011 wb_pc_i  input  32  PC of the retiring instruction.
REQ-012 rvfi_valid_o  output  1  one-cycle retirement pulse.
REQ-013 rvfi_pc_rdata_o  output  32  registered wb_pc_i.
REQ-014 rvfi_mem_addr_o  output  32*NMEM  slot i at bits [i*32 +: 32].
REQ-015 rvfi_mem_rmask_o / rvfi_mem_wmask_o  output  4*NMEM each  slot i at [i*4 +: 4].
REQ-016 rvfi_mem_rdata_o / rvfi_mem_wdata_o  output  32*NMEM each  slot i at [i*32 +: 32].
REQ-017 memop_ovf_o  output  1  sticky overflow flag (see Configuration).

Function
REQ-018 Internal slot counter cnt, range 0..NMEM, and NMEM slot registers {addr, we, be, rdata, wdata}.
REQ-019 lsu_valid_i and cnt<NMEM: capture transfer into slot[cnt]; cnt increments by 1.
REQ-020 lsu_valid_i and cnt==NMEM (full): transfer dropped; slots and cnt unchanged.
REQ-021 wb_valid_i: rvfi_valid_o=1 in the following cycle; rvfi_pc_rdata_o and all rvfi_mem_* outputs update in the same cycle (latency exactly 1 clock).
REQ-022 lsu_valid_i coincident with wb_valid_i: the beat belongs to the retiring instruction and appears in the published slots (at index cnt if cnt<NMEM).
REQ-023 Retirement clears cnt to 0 and all slot byte enables to 0 in the same edge that publishes outputs; no beat leaks to the next instruction.
REQ-024 Slot i published as store: wmask=be, rmask=0, wdata=wdata with bytes outside be forced 0, rdata=0.
REQ-025 Slot i published as load: rmask=be, wmask=0, rdata=rdata with bytes outside be forced 0, wdata=0.
REQ-026 Unused slots (i >= number of captured beats) publish addr, masks, data all 0.
REQ-027 Retirement with no beats: all mask/data/addr fields 0; rvfi_valid_o still pulses.
REQ-028 rvfi_valid_o deasserts the cycle after the pulse unless wb_valid_i was asserted again; back-to-back retirements give consecutive pulses, each with its own slot set.
REQ-029 rvfi_* data outputs hold their last published value between retirements.
REQ-030 lsu_be_i == 0 with lsu_valid_i: beat still occupies a slot, publishes masks 0.

Reset
REQ-031 rst_n low: cnt=0, all slots 0, rvfi_valid_o=0, rvfi_pc_rdata_o=0, all rvfi_mem_* =0, memop_ovf_o=0, asynchronously.
REQ-032 Reset asserted mid-instruction discards captured beats; first retirement after release publishes only beats captured after release.

Configuration
REQ-033 Macro CV32E40X_RVFI_MEMOP_OVF_CHECK_EN defined: memop_ovf_o sets to 1 in the cycle after a drop per REQ-020 and stays 1 until reset; simulation-only error message issued on first drop.
REQ-034 Macro undefined: memop_ovf_o tied 0, no overflow tracking logic; drops per REQ-020 silent.

Verification
REQ-035 Load be=4'b1111 addr=0x1000 rdata=0xDEADBEEF, next cycle wb_valid_i pc=0x80 -> next cycle rvfi_valid_o=1, pc=0x80, slot0 rmask=4'b1111 rdata=0xDEADBEEF, slot1..3 all 0.
REQ-036 Store be=4'b0011 wdata=0xAABBCCDD coincident with wb_valid_i -> slot0 wmask=4'b0011 wdata=0x0000CCDD, rmask=0.
REQ-037 NMEM=4, five stores addr 0x0,0x4,0x8,0xC,0x10 then retire -> slots hold 0x0..0xC, 0x10 absent; with macro memop_ovf_o=1, without 0.
REQ-038 wb_valid_i two consecutive cycles, one load before the first only -> two pulses; second pulse publishes all masks 0.
REQ-039 Two loads captured, rst_n low one cycle, one store, retire -> only the store in slot0, slot1 0, all outputs 0 during reset.

Source files
------------

// File: rtl/cv32e40x_rvfi_memop_collector_if.sv
// ============================================================================
// Module   : cv32e40x_rvfi_memop_collector_if
// Desc     : LSU/writeback inputs and RVFI memory outputs of the memop collector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cv32e40x_rvfi_memop_collector_if #(
  parameter int NMEM = 4
);
  logic                   lsu_valid_i;
  logic                   lsu_we_i;
  logic [3:0]             lsu_be_i;
  logic [31:0]            lsu_addr_i;
  logic [31:0]            lsu_wdata_i;
  logic [31:0]            lsu_rdata_i;
  logic                   wb_valid_i;
  logic [31:0]            wb_pc_i;

  logic                   rvfi_valid_o;
  logic [31:0]            rvfi_pc_rdata_o;
  logic [32*NMEM-1:0]     rvfi_mem_addr_o;
  logic [4*NMEM-1:0]      rvfi_mem_rmask_o;
  logic [4*NMEM-1:0]      rvfi_mem_wmask_o;
  logic [32*NMEM-1:0]     rvfi_mem_rdata_o;
  logic [32*NMEM-1:0]     rvfi_mem_wdata_o;
  logic                   memop_ovf_o;

  modport master (
    output lsu_valid_i, lsu_we_i, lsu_be_i, lsu_addr_i, lsu_wdata_i, lsu_rdata_i,
           wb_valid_i, wb_pc_i,
    input  rvfi_valid_o, rvfi_pc_rdata_o, rvfi_mem_addr_o, rvfi_mem_rmask_o,
           rvfi_mem_wmask_o, rvfi_mem_rdata_o, rvfi_mem_wdata_o, memop_ovf_o
  );

  modport slave (
    input  lsu_valid_i, lsu_we_i, lsu_be_i, lsu_addr_i, lsu_wdata_i, lsu_rdata_i,
           wb_valid_i, wb_pc_i,
    output rvfi_valid_o, rvfi_pc_rdata_o, rvfi_mem_addr_o, rvfi_mem_rmask_o,
           rvfi_mem_wmask_o, rvfi_mem_rdata_o, rvfi_mem_wdata_o, memop_ovf_o
  );
endinterface

`default_nettype wire

// File: rtl/cv32e40x_rvfi_memop_collector.sv
// ============================================================================
// Module   : cv32e40x_rvfi_memop_collector
// Desc     : Gathers LSU beats per instruction, publishes them on RVFI at retire.
//            CV32E40X_RVFI_MEMOP_OVF_CHECK_EN enables the sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cv32e40x_rvfi_memop_collector #(
  parameter int NMEM = 4
) (
  input  wire logic                        clk,
  input  wire logic                        rst_n,
  cv32e40x_rvfi_memop_collector_if.slave   bus
);

  localparam int              c_CW   = $clog2(NMEM + 1);
  localparam logic [c_CW-1:0] c_FULL = c_CW'(NMEM);

  logic [c_CW-1:0] r_cnt;
  logic            r_we    [NMEM];
  logic [3:0]      r_be    [NMEM];
  logic [31:0]     r_addr  [NMEM];
  logic [31:0]     r_rdata [NMEM];
  logic [31:0]     r_wdata [NMEM];

  logic            w_full;
  logic            w_capture;
  logic            w_hit      [NMEM];
  logic [31:0]     w_pub_addr [NMEM];
  logic [3:0]      w_pub_rmsk [NMEM];
  logic [3:0]      w_pub_wmsk [NMEM];
  logic [31:0]     w_pub_rdat [NMEM];
  logic [31:0]     w_pub_wdat [NMEM];

  assign w_full    = (r_cnt == c_FULL);
  assign w_capture = bus.lsu_valid_i && !w_full;

  // Published view of each slot, merging in a beat that lands on the retire edge.
  always_comb begin
    for (int i = 0; i < NMEM; i++) begin
      logic        v_used;
      logic        v_we;
      logic [3:0]  v_be;
      logic [31:0] v_bmask;
      w_hit[i]      = w_capture && (r_cnt == c_CW'(i));
      v_used        = (c_CW'(i) < r_cnt) || w_hit[i];
      v_we          = w_hit[i] ? bus.lsu_we_i : r_we[i];
      v_be          = w_hit[i] ? bus.lsu_be_i : r_be[i];
      v_bmask       = {{8{v_be[3]}}, {8{v_be[2]}}, {8{v_be[1]}}, {8{v_be[0]}}};
      w_pub_addr[i] = '0;
      w_pub_rmsk[i] = '0;
      w_pub_wmsk[i] = '0;
      w_pub_rdat[i] = '0;
      w_pub_wdat[i] = '0;
      if (v_used) begin
        w_pub_addr[i] = w_hit[i] ? bus.lsu_addr_i : r_addr[i];
        if (v_we) begin
          w_pub_wmsk[i] = v_be;
          w_pub_wdat[i] = (w_hit[i] ? bus.lsu_wdata_i : r_wdata[i]) & v_bmask;
        end else begin
          w_pub_rmsk[i] = v_be;
          w_pub_rdat[i] = (w_hit[i] ? bus.lsu_rdata_i : r_rdata[i]) & v_bmask;
        end
      end
    end
  end

  // Slot storage: retirement wipes every slot so nothing carries into the next instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      for (int i = 0; i < NMEM; i++) begin
        r_we[i]    <= 1'b0;
        r_be[i]    <= '0;
        r_addr[i]  <= '0;
        r_rdata[i] <= '0;
        r_wdata[i] <= '0;
      end
    end else if (bus.wb_valid_i) begin
      r_cnt <= '0;
      for (int i = 0; i < NMEM; i++) begin
        r_we[i]    <= 1'b0;
        r_be[i]    <= '0;
        r_addr[i]  <= '0;
        r_rdata[i] <= '0;
        r_wdata[i] <= '0;
      end
    end else if (w_capture) begin
      r_cnt <= r_cnt + c_CW'(1);
      for (int i = 0; i < NMEM; i++) begin
        if (w_hit[i]) begin
          r_we[i]    <= bus.lsu_we_i;
          r_be[i]    <= bus.lsu_be_i;
          r_addr[i]  <= bus.lsu_addr_i;
          r_rdata[i] <= bus.lsu_rdata_i;
          r_wdata[i] <= bus.lsu_wdata_i;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rvfi_valid_o     <= 1'b0;
      bus.rvfi_pc_rdata_o  <= '0;
      bus.rvfi_mem_addr_o  <= '0;
      bus.rvfi_mem_rmask_o <= '0;
      bus.rvfi_mem_wmask_o <= '0;
      bus.rvfi_mem_rdata_o <= '0;
      bus.rvfi_mem_wdata_o <= '0;
    end else begin
      bus.rvfi_valid_o <= bus.wb_valid_i;
      if (bus.wb_valid_i) begin
        bus.rvfi_pc_rdata_o <= bus.wb_pc_i;
        for (int i = 0; i < NMEM; i++) begin
          bus.rvfi_mem_addr_o[i*32 +: 32] <= w_pub_addr[i];
          bus.rvfi_mem_rmask_o[i*4 +: 4]  <= w_pub_rmsk[i];
          bus.rvfi_mem_wmask_o[i*4 +: 4]  <= w_pub_wmsk[i];
          bus.rvfi_mem_rdata_o[i*32 +: 32] <= w_pub_rdat[i];
          bus.rvfi_mem_wdata_o[i*32 +: 32] <= w_pub_wdat[i];
        end
      end
    end
  end

`ifdef CV32E40X_RVFI_MEMOP_OVF_CHECK_EN
  logic w_drop;
  logic r_ovf;

  assign w_drop = bus.lsu_valid_i && w_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end
  end

  assign bus.memop_ovf_o = r_ovf;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n && w_drop && !r_ovf) begin
      $error("cv32e40x_rvfi_memop_collector: LSU beat dropped, all %0d slots in use", NMEM);
    end
  end
`endif
`else
  assign bus.memop_ovf_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cv32e40x_rvfi_memop_collector.sv
// ============================================================================
// Module   : tb_cv32e40x_rvfi_memop_collector
// Desc     : Directed plus random checks of the memop collector against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cv32e40x_rvfi_memop_collector;

  localparam int NMEM = 4;
`ifdef CV32E40X_RVFI_MEMOP_OVF_CHECK_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  cv32e40x_rvfi_memop_collector_if #(.NMEM(NMEM)) bus ();

  cv32e40x_rvfi_memop_collector #(.NMEM(NMEM)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } beat_t;

  beat_t       q[$];
  logic        exp_valid;
  logic [31:0] exp_pc;
  logic [31:0] exp_addr  [NMEM];
  logic [3:0]  exp_rmask [NMEM];
  logic [3:0]  exp_wmask [NMEM];
  logic [31:0] exp_rdata [NMEM];
  logic [31:0] exp_wdata [NMEM];
  logic        exp_ovf;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] byte_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int k = 0; k < 4; k++) m[8*k +: 8] = be[k] ? 8'hFF : 8'h00;
    return m;
  endfunction

  task automatic model_reset();
    q.delete();
    exp_valid = 1'b0;
    exp_pc    = '0;
    exp_ovf   = 1'b0;
    for (int i = 0; i < NMEM; i++) begin
      exp_addr[i] = '0; exp_rmask[i] = '0; exp_wmask[i] = '0;
      exp_rdata[i] = '0; exp_wdata[i] = '0;
    end
  endtask

  // Applies the inputs seen at a rising edge to the reference model.
  task automatic model_edge();
    if (bus.lsu_valid_i) begin
      if (q.size() < NMEM) begin
        beat_t b;
        b.we = bus.lsu_we_i; b.be = bus.lsu_be_i; b.addr = bus.lsu_addr_i;
        b.wdata = bus.lsu_wdata_i; b.rdata = bus.lsu_rdata_i;
        q.push_back(b);
      end else if (OVF_EN) begin
        exp_ovf = 1'b1;
      end
    end
    exp_valid = bus.wb_valid_i;
    if (bus.wb_valid_i) begin
      exp_pc = bus.wb_pc_i;
      for (int i = 0; i < NMEM; i++) begin
        exp_addr[i] = '0; exp_rmask[i] = '0; exp_wmask[i] = '0;
        exp_rdata[i] = '0; exp_wdata[i] = '0;
        if (i < q.size()) begin
          exp_addr[i] = q[i].addr;
          if (q[i].we) begin
            exp_wmask[i] = q[i].be;
            exp_wdata[i] = q[i].wdata & byte_mask(q[i].be);
          end else begin
            exp_rmask[i] = q[i].be;
            exp_rdata[i] = q[i].rdata & byte_mask(q[i].be);
          end
        end
      end
      q.delete();
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 32'(bus.rvfi_valid_o), 32'(exp_valid));
    chk({tag, ".pc"}, bus.rvfi_pc_rdata_o, exp_pc);
    for (int i = 0; i < NMEM; i++) begin
      chk($sformatf("%s.addr%0d", tag, i), bus.rvfi_mem_addr_o[i*32 +: 32], exp_addr[i]);
      chk($sformatf("%s.rmask%0d", tag, i), 32'(bus.rvfi_mem_rmask_o[i*4 +: 4]), 32'(exp_rmask[i]));
      chk($sformatf("%s.wmask%0d", tag, i), 32'(bus.rvfi_mem_wmask_o[i*4 +: 4]), 32'(exp_wmask[i]));
      chk($sformatf("%s.rdata%0d", tag, i), bus.rvfi_mem_rdata_o[i*32 +: 32], exp_rdata[i]);
      chk($sformatf("%s.wdata%0d", tag, i), bus.rvfi_mem_wdata_o[i*32 +: 32], exp_wdata[i]);
    end
    chk({tag, ".ovf"}, 32'(bus.memop_ovf_o), 32'(exp_ovf));
  endtask

  task automatic step(input string tag, input logic lv, input logic we, input logic [3:0] be,
                      input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                      input logic wv, input logic [31:0] pc);
    @(negedge clk);
    bus.lsu_valid_i = lv; bus.lsu_we_i = we; bus.lsu_be_i = be; bus.lsu_addr_i = addr;
    bus.lsu_wdata_i = wd; bus.lsu_rdata_i = rd; bus.wb_valid_i = wv; bus.wb_pc_i = pc;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  // Reset is asserted between edges so the outputs must clear without a clock.
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    bus.lsu_valid_i = 1'b0; bus.wb_valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(posedge clk);
    #1;
    check_all({tag, ".hold"});
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.lsu_valid_i = 1'b0; bus.lsu_we_i = 1'b0; bus.lsu_be_i = '0; bus.lsu_addr_i = '0;
    bus.lsu_wdata_i = '0; bus.lsu_rdata_i = '0; bus.wb_valid_i = 1'b0; bus.wb_pc_i = '0;
    model_reset();
    #2;
    pulse_reset("reset");

    // Load then retire on the next cycle.
    step("ld", 1'b1, 1'b0, 4'hF, 32'h1000, 32'h0, 32'hDEADBEEF, 1'b0, 32'h0);
    step("ld_ret", 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h80);
    chk("ld_ret.const_rdata0", bus.rvfi_mem_rdata_o[31:0], 32'hDEADBEEF);
    idle("ld_hold");

    // Partial store coincident with retirement.
    step("st_co", 1'b1, 1'b1, 4'b0011, 32'h2000, 32'hAABBCCDD, 32'h11223344, 1'b1, 32'h84);
    chk("st_co.const_wdata0", bus.rvfi_mem_wdata_o[31:0], 32'h0000CCDD);

    // Five stores into four slots; the fifth is dropped.
    for (int k = 0; k < 5; k++)
      step($sformatf("ovf_st%0d", k), 1'b1, 1'b1, 4'hF, 32'(4 * k), 32'(k + 1), 32'h0, 1'b0, 32'h0);
    step("ovf_ret", 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h88);
    chk("ovf_ret.const_addr3", bus.rvfi_mem_addr_o[127:96], 32'hC);

    // Back-to-back retirements, only the first owns a beat.
    step("b2b_ld", 1'b1, 1'b0, 4'h3, 32'h3000, 32'h0, 32'h12345678, 1'b0, 32'h0);
    step("b2b_r1", 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h90);
    step("b2b_r2", 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h94);
    chk("b2b_r2.const_rmask0", 32'(bus.rvfi_mem_rmask_o), 32'h0);
    idle("b2b_idle");

    // Beats captured before a reset must not reach the next retirement.
    step("rst_ld0", 1'b1, 1'b0, 4'hF, 32'h4000, 32'h0, 32'hCAFE0000, 1'b0, 32'h0);
    step("rst_ld1", 1'b1, 1'b0, 4'hF, 32'h4004, 32'h0, 32'hCAFE0001, 1'b0, 32'h0);
    pulse_reset("rst_mid");
    step("rst_st", 1'b1, 1'b1, 4'hC, 32'h5000, 32'h99887766, 32'h0, 1'b0, 32'h0);
    step("rst_ret", 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b1, 32'hA0);
    chk("rst_ret.const_addr1", bus.rvfi_mem_addr_o[63:32], 32'h0);

    // Zero byte-enable beat still consumes a slot.
    step("be0_ld", 1'b1, 1'b0, 4'h0, 32'h6000, 32'h0, 32'hFFFFFFFF, 1'b0, 32'h0);
    step("be0_st", 1'b1, 1'b1, 4'h1, 32'h6004, 32'h000000AB, 32'h0, 1'b1, 32'hA4);

    for (int n = 0; n < 400; n++) begin
      if (n == 200) pulse_reset("rnd_rst");
      step($sformatf("rnd%0d", n),
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 15)),
           $urandom, $urandom, $urandom,
           ($urandom_range(0, 3) == 0), $urandom);
    end
    idle("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
